// File: rtl/udp_tx_chan_arb.sv
// Merges NUM_CH user AXIS streams into the single UDP TX stream with per-packet arbitration.
// Default is round-robin; defining UDP_TX_ARB_PRIO_EN selects fixed lowest-index priority.
module udp_tx_chan_arb #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 64,
   parameter int KEEP_W = DATA_W/8
) (
   input  logic                       tx_axis_aclk,
   input  logic                       tx_axis_areset,
   input  logic                       udp_enable,
   input  logic [NUM_CH*16-1:0]       ch_src_port,
   input  logic [NUM_CH*16-1:0]       ch_dst_port,
   input  logic [NUM_CH*DATA_W-1:0]   s_axis_tdata,
   input  logic [NUM_CH*KEEP_W-1:0]   s_axis_tkeep,
   input  logic [NUM_CH-1:0]          s_axis_tvalid,
   input  logic [NUM_CH-1:0]          s_axis_tlast,
   output logic [NUM_CH-1:0]          s_axis_tready,
   output logic [DATA_W-1:0]          udp_tx_axis_tdata,
   output logic [KEEP_W-1:0]          udp_tx_axis_tkeep,
   output logic                       udp_tx_axis_tvalid,
   output logic                       udp_tx_axis_tlast,
   input  logic                       udp_tx_axis_tready,
   output logic [15:0]                sel_src_port,
   output logic [15:0]                sel_dst_port,
   output logic [$clog2(NUM_CH)-1:0]  sel_ch,
   output logic                       pkt_drop
);

   localparam int CH_W = $clog2(NUM_CH);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DROP
   } state_t;

   state_t            state_q,        state_d;
   logic [CH_W-1:0]   sel_ch_q,       sel_ch_d;
   logic [15:0]       sel_src_port_q, sel_src_port_d;
   logic [15:0]       sel_dst_port_q, sel_dst_port_d;
`ifndef UDP_TX_ARB_PRIO_EN
   logic [CH_W-1:0]   last_grant_q,   last_grant_d;
`endif

   logic [DATA_W-1:0] ch_data [NUM_CH];
   logic [KEEP_W-1:0] ch_keep [NUM_CH];
   logic [15:0]       ch_src  [NUM_CH];
   logic [15:0]       ch_dst  [NUM_CH];

   logic              grant_vld;
   logic [CH_W-1:0]   grant_idx;
   logic              cur_valid;
   logic              cur_last;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
         assign ch_data[gi] = s_axis_tdata[DATA_W*gi +: DATA_W];
         assign ch_keep[gi] = s_axis_tkeep[KEEP_W*gi +: KEEP_W];
         assign ch_src[gi]  = ch_src_port[16*gi +: 16];
         assign ch_dst[gi]  = ch_dst_port[16*gi +: 16];
         // Only the granted channel sees ready; drops are sunk regardless of downstream.
         assign s_axis_tready[gi] = (sel_ch_q == CH_W'(gi)) &&
                                    (((state_q == XFER) && udp_tx_axis_tready) ||
                                     (state_q == DROP));
      end
   endgenerate

`ifdef UDP_TX_ARB_PRIO_EN
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = NUM_CH-1; i >= 0; i--) begin
         if (s_axis_tvalid[CH_W'(i)]) begin
            grant_vld = 1'b1;
            grant_idx = CH_W'(i);
         end
      end
   end
`else
   always_comb begin
      int cand;
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      // Scan starts just after the last winner and wraps, so the last winner is tried last.
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = (int'(last_grant_q) + k) % NUM_CH;
         if (!grant_vld && s_axis_tvalid[CH_W'(cand)]) begin
            grant_vld = 1'b1;
            grant_idx = CH_W'(cand);
         end
      end
   end
`endif

   assign cur_valid = s_axis_tvalid[sel_ch_q];
   assign cur_last  = s_axis_tlast[sel_ch_q];

   always_comb begin
      state_d            = state_q;
      sel_ch_d           = sel_ch_q;
      sel_src_port_d     = sel_src_port_q;
      sel_dst_port_d     = sel_dst_port_q;
`ifndef UDP_TX_ARB_PRIO_EN
      last_grant_d       = last_grant_q;
`endif
      udp_tx_axis_tdata  = '0;
      udp_tx_axis_tkeep  = '0;
      udp_tx_axis_tvalid = 1'b0;
      udp_tx_axis_tlast  = 1'b0;
      pkt_drop           = 1'b0;

      case (state_q)
         IDLE: begin
            if (udp_enable && grant_vld) begin
               sel_ch_d       = grant_idx;
               sel_src_port_d = ch_src[grant_idx];
               sel_dst_port_d = ch_dst[grant_idx];
               state_d        = (ch_dst[grant_idx] == 16'h0000) ? DROP : XFER;
            end
         end

         XFER: begin
            udp_tx_axis_tdata  = ch_data[sel_ch_q];
            udp_tx_axis_tkeep  = ch_keep[sel_ch_q];
            udp_tx_axis_tvalid = cur_valid;
            udp_tx_axis_tlast  = cur_last;
            if (cur_valid && udp_tx_axis_tready && cur_last) begin
`ifndef UDP_TX_ARB_PRIO_EN
               last_grant_d = sel_ch_q;
`endif
               state_d = IDLE;
            end
         end

         DROP: begin
            if (cur_valid && cur_last) begin
               pkt_drop = 1'b1;
`ifndef UDP_TX_ARB_PRIO_EN
               last_grant_d = sel_ch_q;
`endif
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge tx_axis_aclk) begin
      if (tx_axis_areset) begin
         state_q        <= IDLE;
         sel_ch_q       <= '0;
         sel_src_port_q <= '0;
         sel_dst_port_q <= '0;
`ifndef UDP_TX_ARB_PRIO_EN
         last_grant_q   <= CH_W'(NUM_CH-1);
`endif
      end else begin
         state_q        <= state_d;
         sel_ch_q       <= sel_ch_d;
         sel_src_port_q <= sel_src_port_d;
         sel_dst_port_q <= sel_dst_port_d;
`ifndef UDP_TX_ARB_PRIO_EN
         last_grant_q   <= last_grant_d;
`endif
      end
   end

   assign sel_ch       = sel_ch_q;
   assign sel_src_port = sel_src_port_q;
   assign sel_dst_port = sel_dst_port_q;

endmodule

// File: tb/tb_udp_tx_chan_arb.sv
// Randomized bench for udp_tx_chan_arb: per-channel packet sources, a packet-ownership
// reference model of the arbiter, and per-cycle comparison of all DUT outputs.
module tb_udp_tx_chan_arb;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 64;
   localparam int KEEP_W = DATA_W/8;
   localparam int CH_W   = $clog2(NUM_CH);
   localparam int NCYC   = 4000;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic                      udp_enable = 1'b0;
   logic [NUM_CH*16-1:0]      ch_src_port = '0;
   logic [NUM_CH*16-1:0]      ch_dst_port = '0;
   logic [NUM_CH*DATA_W-1:0]  s_axis_tdata = '0;
   logic [NUM_CH*KEEP_W-1:0]  s_axis_tkeep = '0;
   logic [NUM_CH-1:0]         s_axis_tvalid = '0;
   logic [NUM_CH-1:0]         s_axis_tlast = '0;
   logic [NUM_CH-1:0]         s_axis_tready;
   logic [DATA_W-1:0]         udp_tx_axis_tdata;
   logic [KEEP_W-1:0]         udp_tx_axis_tkeep;
   logic                      udp_tx_axis_tvalid;
   logic                      udp_tx_axis_tlast;
   logic                      udp_tx_axis_tready = 1'b0;
   logic [15:0]               sel_src_port;
   logic [15:0]               sel_dst_port;
   logic [CH_W-1:0]           sel_ch;
   logic                      pkt_drop;

   always #5 clk = ~clk;

   udp_tx_chan_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
      .tx_axis_aclk       (clk),
      .tx_axis_areset     (rst),
      .udp_enable         (udp_enable),
      .ch_src_port        (ch_src_port),
      .ch_dst_port        (ch_dst_port),
      .s_axis_tdata       (s_axis_tdata),
      .s_axis_tkeep       (s_axis_tkeep),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tlast       (s_axis_tlast),
      .s_axis_tready      (s_axis_tready),
      .udp_tx_axis_tdata  (udp_tx_axis_tdata),
      .udp_tx_axis_tkeep  (udp_tx_axis_tkeep),
      .udp_tx_axis_tvalid (udp_tx_axis_tvalid),
      .udp_tx_axis_tlast  (udp_tx_axis_tlast),
      .udp_tx_axis_tready (udp_tx_axis_tready),
      .sel_src_port       (sel_src_port),
      .sel_dst_port       (sel_dst_port),
      .sel_ch             (sel_ch),
      .pkt_drop           (pkt_drop)
   );

   typedef struct {
      logic [DATA_W-1:0] d;
      logic [KEEP_W-1:0] k;
      logic              l;
   } beat_t;

   beat_t srcq [NUM_CH][$];
   bit    offering [NUM_CH];

   int checks = 0;
   int errors = 0;

   // Reference model: which channel owns the output, and whether its packet is discarded.
   int          owner    = -1;
   bit          own_drop = 1'b0;
   int          rr_last  = NUM_CH-1;
   int          lat_ch   = 0;
   logic [15:0] lat_src  = '0;
   logic [15:0] lat_dst  = '0;
   int          beats    = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic int pick(input logic [NUM_CH-1:0] v);
`ifdef UDP_TX_ARB_PRIO_EN
      for (int i = 0; i < NUM_CH; i++)
         if (v[i]) return i;
`else
      for (int k = 1; k <= NUM_CH; k++) begin
         int c;
         c = (rr_last + k) % NUM_CH;
         if (v[c]) return c;
      end
`endif
      return -1;
   endfunction

   task automatic new_ports(input int ch);
      ch_src_port[ch*16 +: 16] = 16'($urandom);
      ch_dst_port[ch*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
   endtask

   task automatic drive_inputs(input int p_pkt, input int p_rdy, input int p_en, input int p_port);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (srcq[ch].size() < 3 && $urandom_range(0, 99) < p_pkt) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
               beat_t bt;
               bt.d = {$urandom, $urandom};
               bt.k = 8'($urandom);
               bt.l = (b == len-1);
               srcq[ch].push_back(bt);
            end
         end
         if (!offering[ch] && srcq[ch].size() > 0 && $urandom_range(0, 3) != 0)
            offering[ch] = 1'b1;
         s_axis_tvalid[ch] = offering[ch];
         if (offering[ch]) begin
            s_axis_tdata[ch*DATA_W +: DATA_W] = srcq[ch][0].d;
            s_axis_tkeep[ch*KEEP_W +: KEEP_W] = srcq[ch][0].k;
            s_axis_tlast[ch]                  = srcq[ch][0].l;
         end else begin
            s_axis_tdata[ch*DATA_W +: DATA_W] = {$urandom, $urandom};
            s_axis_tkeep[ch*KEEP_W +: KEEP_W] = 8'($urandom);
            s_axis_tlast[ch]                  = 1'($urandom);
         end
         if ($urandom_range(0, 99) < p_port)
            new_ports(ch);
      end
      udp_tx_axis_tready = ($urandom_range(0, 99) < p_rdy);
      if (p_en < 0)
         udp_enable = 1'b1;
      else if ($urandom_range(0, 99) < p_en)
         udp_enable = ~udp_enable;
   endtask

   initial begin
      for (int ch = 0; ch < NUM_CH; ch++) new_ports(ch);
      repeat (2) @(posedge clk);

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         logic [NUM_CH-1:0] exp_rdy;
         logic              exp_val;
         logic [DATA_W-1:0] exp_data;
         logic [KEEP_W-1:0] exp_keep;
         logic              exp_drop;

         @(negedge clk);
         rst = (cyc < 2) || (cyc >= 1000 && cyc < 1002) || (cyc >= 2600 && cyc < 2603);
         if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
               srcq[ch].delete();
               offering[ch] = 1'b0;
            end
            s_axis_tvalid      = '0;
            s_axis_tlast       = '0;
            udp_tx_axis_tready = 1'b1;
         end else if (cyc < 1500) begin
            drive_inputs(30, 70, 3, 2);
         end else if (cyc < 3000) begin
            drive_inputs(60, 100, -1, 1);
         end else begin
            drive_inputs(40, 30, 6, 3);
         end
         #1;

         exp_rdy  = '0;
         exp_val  = 1'b0;
         exp_data = '0;
         exp_keep = '0;
         exp_drop = 1'b0;
         if (owner >= 0) begin
            if (own_drop) begin
               exp_rdy[owner] = 1'b1;
               exp_drop       = s_axis_tvalid[owner] && s_axis_tlast[owner];
            end else begin
               exp_rdy[owner] = udp_tx_axis_tready;
               exp_val        = s_axis_tvalid[owner];
               exp_data       = s_axis_tdata[owner*DATA_W +: DATA_W];
               exp_keep       = s_axis_tkeep[owner*KEEP_W +: KEEP_W];
            end
         end

         check("s_axis_tready", 64'(s_axis_tready), 64'(exp_rdy));
         check("tx_tvalid", 64'(udp_tx_axis_tvalid), 64'(exp_val));
         check("tx_tdata", 64'(udp_tx_axis_tdata), 64'(exp_data));
         check("tx_tkeep", 64'(udp_tx_axis_tkeep), 64'(exp_keep));
         if (exp_val)
            check("tx_tlast", 64'(udp_tx_axis_tlast), 64'(s_axis_tlast[owner]));
         check("pkt_drop", 64'(pkt_drop), 64'(exp_drop));
         check("sel_ch", 64'(sel_ch), 64'(lat_ch));
         check("sel_src_port", 64'(sel_src_port), 64'(lat_src));
         check("sel_dst_port", 64'(sel_dst_port), 64'(lat_dst));

         if (rst) begin
            owner    = -1;
            own_drop = 1'b0;
            rr_last  = NUM_CH-1;
            lat_ch   = 0;
            lat_src  = '0;
            lat_dst  = '0;
            beats    = 0;
         end else if (owner >= 0) begin
            if (s_axis_tvalid[owner] && exp_rdy[owner]) begin
               void'(srcq[owner].pop_front());
               offering[owner] = 1'b0;
               beats++;
               if (s_axis_tlast[owner]) begin
                  $display("pkt ch=%0d src=%h dst=%h beats=%0d %s", owner, lat_src, lat_dst,
                           beats, own_drop ? "dropped" : "sent");
                  rr_last = owner;
                  owner   = -1;
                  beats   = 0;
               end
            end
         end else if (udp_enable && (|s_axis_tvalid)) begin
            owner    = pick(s_axis_tvalid);
            lat_ch   = owner;
            lat_src  = ch_src_port[owner*16 +: 16];
            lat_dst  = ch_dst_port[owner*16 +: 16];
            own_drop = (lat_dst == 16'h0000);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
